demux1to8_deser: RTL
====================

Name: demux1to8_deser

Overview:
- Receive-side counterpart of the 8:1 bit-select mux.
- The transmit side walks sel 0..7 over an 8-bit word and emits one bit per step. This block takes that serial bit stream and steers each bit into its slot by a 3-bit index counter, rebuilding the parallel word.
- Sits directly after the mux-based serializer. Delivers completed bytes with a one-cycle valid pulse.

Parameters:
- WIDTH, 8, word width in bits; must be a power of two ≥ 2.
- SEL_W, $clog2(WIDTH) = 3, index counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  in_bit is valid this cycle.
- in_start  input  1  qualifies the bit that has in_valid as index 0 of a new word.
- in_bit  input  1  serial data bit; LSB first, i.e. sel 0 first.
- data_out  output  WIDTH  last completed word; held until the next completion.
- out_valid  output  1  one-cycle pulse when data_out updates.
- sel  output  SEL_W  index the next accepted bit will be written to.
- busy  output  1  high while a word is partially collected.
- frame_err  output  1  one-cycle pulse when a partial word is aborted by in_start.
- par_err  output  1  parity mismatch flag, valid with out_valid (see Optional Feature).

Behaviour:
- Reset (clk edge with rst=1): state=IDLE; sel=0; shadow register=0; data_out=0; out_valid=0; busy=0; frame_err=0; par_err=0. Reset wins over every other input, including mid-word; a partial word is discarded without frame_err.
- Storage: an internal shadow register collects bits; data_out is a separate register loaded only on completion.
- State IDLE (busy=0, sel=0):
  - in_valid & in_start: shadow[0]=in_bit, sel=1, go COLLECT.
  - in_valid & !in_start: bit ignored, stay IDLE.
  - in_start without in_valid: ignored.
- State COLLECT (busy=1):
  - in_valid & !in_start: shadow[sel]=in_bit, sel=sel+1.
  - When the accepted bit has sel==WIDTH-1:
    - without parity: data_out = shadow with that bit merged; out_valid=1 next cycle; sel wraps to 0; go IDLE.
    - with parity: go PARITY.
  - in_valid & in_start: abort. frame_err pulses 1 cycle; shadow cleared; shadow[0]=in_bit; sel=1; stay COLLECT. data_out is unchanged and out_valid is not pulsed.
  - in_valid=0: hold; no timeout.
- Latency: out_valid and data_out appear in the cycle after the clock edge that accepted the final bit (registered, 1-cycle latency). out_valid is high exactly one cycle.
- Back-to-back words: a word's in_start bit may arrive in the cycle immediately after its final bit, so there are zero idle cycles between words.
- sel is a registered counter. It never exceeds WIDTH-1, and wrap-around to 0 happens only on completion or reset.
- No backpressure: a completed word overwrites data_out regardless of whether it was consumed.

Optional Feature:
- Macro: DEMUX_PARITY_CHK_EN.
- Defined:
  - Adds state PARITY after bit WIDTH-1.
  - Next in_valid bit is even parity over the word.
  - in_valid & !in_start in PARITY: data_out=shadow, out_valid pulses, par_err = (^shadow ^ in_bit); go IDLE.
  - in_valid & in_start in PARITY: abort as in COLLECT (frame_err, restart at index 0).
  - busy stays 1 in PARITY; sel holds WIDTH-1.
- Undefined: no PARITY state; par_err tied 0.

Decomposition:
- Shared package demux_pkg holds:
  - state enum {ST_IDLE, ST_COLLECT, ST_PARITY};
  - default WIDTH localparam;
  - parity function used by both this block and the serializer bench.
- One natural sub-module: demux_idx_cnt, the SEL_W-bit index counter with load-to-1, increment, and wrap/clear. The top contains the FSM and registers.

Test Plan:
- Reset: hold rst 2 cycles mid-word after 3 bits → sel=0, busy=0, data_out=0, no out_valid, no frame_err.
- Basic word 8'b10011101: in_start on the first bit; bits 1,0,1,1,1,0,0,1 on 8 consecutive valid cycles → data_out=8'h9D, out_valid high exactly 1 cycle after the 8th bit; sel sequence 1..7,0.
- Gapped input: same word with in_valid low for 2 cycles between each bit → identical result 8'h9D, sel holds during gaps.
- Back-to-back: 8'h9D then 8'h3C with zero idle cycles → two out_valid pulses 8 cycles apart, data_out 8'h9D then 8'h3C.
- Abort: 5 bits of a word, then in_start with bit 1, then 7 bits of 8'hA5 completing → frame_err single pulse; data_out=8'hA5 only.
- With DEMUX_PARITY_CHK_EN: 8'h9D (five 1s) followed by parity bit 1 → par_err=0; same word with parity bit 0 → par_err=1. out_valid occurs 1 cycle after the parity bit.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared state encoding, default width and even-parity helper for the deserializer path
package demux_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_PARITY} state_t;
  function automatic logic parity(input logic [63:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/demux_idx_cnt.sv
// demux_idx_cnt: slot index counter with clear, load-to-1 and increment
module demux_idx_cnt #(
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_inc,
  output logic [SEL_W-1:0] o_sel
);
  logic [SEL_W-1:0] r_sel;
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_sel <= '0;
    else if (i_load) r_sel <= SEL_W'(1);
    else if (i_inc) r_sel <= r_sel + SEL_W'(1);
  end
  assign o_sel = r_sel;
endmodule

// File: rtl/demux1to8_deser.sv
// demux1to8_deser: rebuilds LSB-first serial words into parallel bytes with a one-cycle valid pulse
// Defining DEMUX_PARITY_CHK_EN adds a trailing even-parity bit per word and drives par_err.
module demux1to8_deser
  import demux_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  localparam int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_start,
  input  logic             in_bit,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             frame_err,
  output logic             par_err
);
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shadow, w_shadow_nxt, r_data;
  logic             r_out_valid, r_frame_err;
  logic             w_start, w_bit, w_last, w_done, w_inc, w_clr;
  logic [SEL_W-1:0] w_sel;
  assign w_start = in_valid & in_start;
  assign w_bit   = in_valid & ~in_start;
  assign w_last  = w_sel == SEL_W'(WIDTH - 1);
  demux_idx_cnt #(.SEL_W(SEL_W)) u_idx (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_load(w_start),
    .i_inc (w_inc),
    .o_sel (w_sel)
  );
  // a start bit always restarts at slot 0, which doubles as the abort path mid-word
  always_comb begin
    w_state_nxt  = r_state;
    w_shadow_nxt = r_shadow;
    w_done       = 1'b0;
    w_inc        = 1'b0;
    w_clr        = 1'b0;
    if (w_start) begin
      w_state_nxt  = ST_COLLECT;
      w_shadow_nxt = WIDTH'(in_bit);
    end else if (w_bit && r_state == ST_COLLECT) begin
      w_shadow_nxt[w_sel] = in_bit;
      w_inc               = ~w_last;
`ifdef DEMUX_PARITY_CHK_EN
      w_state_nxt = w_last ? ST_PARITY : ST_COLLECT;
`else
      w_done      = w_last;
      w_clr       = w_last;
      w_state_nxt = w_last ? ST_IDLE : ST_COLLECT;
`endif
    end
`ifdef DEMUX_PARITY_CHK_EN
    else if (w_bit && r_state == ST_PARITY) begin
      w_done      = 1'b1;
      w_clr       = 1'b1;
      w_state_nxt = ST_IDLE;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shadow    <= '0;
      r_data      <= '0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shadow    <= w_shadow_nxt;
      r_data      <= w_done ? w_shadow_nxt : r_data;
      r_out_valid <= w_done;
      r_frame_err <= w_start & (r_state != ST_IDLE);
    end
  end
`ifdef DEMUX_PARITY_CHK_EN
  logic r_par_err;
  always_ff @(posedge clk) begin
    if (rst) r_par_err <= 1'b0;
    else r_par_err <= w_done & (parity(64'(r_shadow)) ^ in_bit);
  end
  assign par_err = r_par_err;
`else
  assign par_err = 1'b0;
`endif
  assign data_out  = r_data;
  assign out_valid = r_out_valid;
  assign sel       = w_sel;
  assign busy      = r_state != ST_IDLE;
  assign frame_err = r_frame_err;
endmodule
